glb_port_arbiter: RTL and testbench

GLB_PORT_ARBITER -- requirements
Module: glb_port_arbiter

---
 rtl/glb_port_arbiter_pkg.sv | 20 ++
 rtl/glb_port_arbiter_rr_priority_enc.sv | 28 ++
 rtl/glb_port_arbiter.sv | 97 +++++++++
 tb/tb_glb_port_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/glb_port_arbiter_pkg.sv
// Shared definitions for the GLB port arbiter and the token-engine FIFO controllers.
package glb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } arb_state_e;

  localparam int GLB_RD_LATENCY = 1;

  localparam int IFMAP  = 0;
  localparam int FILTER = 1;
  localparam int IPSUM  = 2;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/glb_port_arbiter_rr_priority_enc.sv
// Rotating priority encoder: grants the first set req bit at or after ptr, wrapping.
module rr_priority_enc #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        gnt     = '0;
        gnt[k]  = 1'b1;
        gnt_idx = PW'(k);
      end
    end
  end

endmodule

// File: rtl/glb_port_arbiter.sv
// Single-port GLB arbiter: write-priority, round-robin reads, flush/drain FSM.
module glb_port_arbiter
  import glb_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arb_en_i,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        rd_req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr_i,
  input  logic                      wr_req_i,
  input  logic [ADDR_W-1:0]         wr_addr_i,
  input  logic [31:0]               wr_data_i,
  output logic [NUM_REQ-1:0]        rd_permit_o,
  output logic                      wr_permit_o,
  output logic                      glb_en_o,
  output logic                      glb_we_o,
  output logic [ADDR_W-1:0]         glb_addr_o,
  output logic [31:0]               glb_wdata_o,
  output logic [NUM_REQ-1:0]        rdata_owner_o,
  output logic                      busy_o,
  output logic                      drain_done_o
);

  localparam int PW = ptr_w(NUM_REQ);

  arb_state_e                       state_q, state_d;
  logic [PW-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]               owner_q;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   rd_addr;
  logic [NUM_REQ-1:0]               enc_gnt;
  logic [PW-1:0]                    enc_idx;
  logic                             grant_ok, wr_gnt, rd_any;
  logic [NUM_REQ-1:0]               rd_gnt;

  assign rd_addr = rd_addr_i;

  rr_priority_enc #(.N(NUM_REQ), .PW(PW)) u_enc (
    .req     (rd_req_i),
    .ptr     (rr_ptr_q),
    .gnt     (enc_gnt),
    .gnt_idx (enc_idx)
  );

  // arb_en_i low or flush_i in ACTIVE blocks this cycle's grant as well as leaving ACTIVE.
  assign grant_ok = (state_q == ACTIVE) && arb_en_i && !flush_i;
  assign wr_gnt   = grant_ok && wr_req_i;
  assign rd_gnt   = (grant_ok && !wr_req_i) ? enc_gnt : '0;
  assign rd_any   = |rd_gnt;

  always_comb begin
    state_d      = state_q;
    drain_done_o = 1'b0;
    case (state_q)
      IDLE:    if (arb_en_i) state_d = ACTIVE;
      ACTIVE:  if (flush_i || !arb_en_i) state_d = DRAIN;
      DRAIN: begin
        if (owner_q == '0) begin
          state_d      = IDLE;
          drain_done_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (rd_any) rr_ptr_d = (enc_idx == PW'(NUM_REQ - 1)) ? '0 : enc_idx + PW'(1);
  end

  // GLB read data returns GLB_RD_LATENCY (=1) cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= rd_gnt;
    end
  end

  assign rd_permit_o   = rd_gnt;
  assign wr_permit_o   = wr_gnt;
  assign glb_en_o      = wr_gnt || rd_any;
  assign glb_we_o      = wr_gnt;
  assign glb_addr_o    = wr_gnt ? wr_addr_i : (rd_any ? rd_addr[enc_idx] : '0);
  assign glb_wdata_o   = wr_gnt ? wr_data_i : '0;
  assign rdata_owner_o = owner_q;
  assign busy_o        = wr_gnt || (state_q == DRAIN);

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Scoreboard bench for glb_port_arbiter: directed steps push expectations, a negedge monitor checks.
module tb_glb_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int GW = 1 + 1 + N + 1 + AW + 32;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            arb_en = 1'b0, flush = 1'b0, wr_req = 1'b0;
  logic [N-1:0]    rd_req = '0;
  logic [N*AW-1:0] rd_addr;
  logic [AW-1:0]   wr_addr = 32'h80;
  logic [31:0]     wr_data = 32'hDEAD_BEEF;

  logic [N-1:0]    rd_permit, rdata_owner;
  logic            wr_permit, glb_en, glb_we, busy, drain_done;
  logic [AW-1:0]   glb_addr;
  logic [31:0]     glb_wdata;

  logic [AW-1:0]   addr_tab [N] = '{32'h10, 32'h24, 32'h40, 32'h5C};

  logic [GW-1:0]   gnt_q [$];
  logic [N-1:0]    own_q [$];
  logic [1:0]      st_q  [$];

  int n_cmp = 0, n_err = 0;

  glb_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arb_en_i      (arb_en),
    .flush_i       (flush),
    .rd_req_i      (rd_req),
    .rd_addr_i     (rd_addr),
    .wr_req_i      (wr_req),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .rd_permit_o   (rd_permit),
    .wr_permit_o   (wr_permit),
    .glb_en_o      (glb_en),
    .glb_we_o      (glb_we),
    .glb_addr_o    (glb_addr),
    .glb_wdata_o   (glb_wdata),
    .rdata_owner_o (rdata_owner),
    .busy_o        (busy),
    .drain_done_o  (drain_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: grant bundle {en, wr, rd, we, addr, wdata}, owner, and {busy, drain_done}.
  always @(negedge clk) begin
    if (rst_n) begin
      if (glb_en || wr_permit || (|rd_permit)) begin
        if (gnt_q.size() == 0)
          chk("unexpected_grant", {glb_en, wr_permit, rd_permit, glb_we, glb_addr, glb_wdata}, '0);
        else
          chk("grant", {glb_en, wr_permit, rd_permit, glb_we, glb_addr, glb_wdata}, gnt_q.pop_front());
      end
      if (|rdata_owner) begin
        if (own_q.size() == 0) chk("unexpected_owner", rdata_owner, '0);
        else                   chk("rdata_owner", rdata_owner, own_q.pop_front());
      end
      if (st_q.size() != 0) chk("busy_drain", {busy, drain_done}, st_q.pop_front());
    end
  end

  // One cycle of stimulus. g: -1 none, 0..N-1 read index, N write.
  task automatic step(input logic en, input logic fl, input logic wr, input logic [N-1:0] req,
                      input int g, input logic eb, input logic edd);
    logic [N-1:0] oh;
    @(posedge clk); #1;
    arb_en = en; flush = fl; wr_req = wr; rd_req = req;
    oh = '0;
    if (g == N) begin
      gnt_q.push_back({1'b1, 1'b1, {N{1'b0}}, 1'b1, wr_addr, wr_data});
    end else if (g >= 0 && g < N) begin
      oh[g] = 1'b1;
      gnt_q.push_back({1'b1, 1'b0, oh, 1'b0, addr_tab[g], 32'h0});
      own_q.push_back(oh);
    end
    st_q.push_back({eb, edd});
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {rd_permit, wr_permit, glb_en, glb_we, busy, drain_done, rdata_owner, glb_addr, glb_wdata}, '0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) rd_addr[k*AW +: AW] = addr_tab[k];
    // Active inputs during reset must not leak through.
    arb_en = 1'b1; wr_req = 1'b1; rd_req = 4'b1111;
    #12 chk_all_zero("reset_outputs");
    arb_en = 1'b0; wr_req = 1'b0; rd_req = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    step(0, 0, 0, 4'b1111, -1, 0, 0);   // IDLE, disabled
    step(0, 1, 0, 4'b1111, -1, 0, 0);   // flush in IDLE is a no-op
    step(1, 0, 0, 4'b1111, -1, 0, 0);   // IDLE -> ACTIVE
    for (int i = 0; i < 8; i++) step(1, 0, 0, 4'b1111, i % N, 0, 0);
    step(1, 0, 1, 4'b1111,  N, 1, 0);   // write priority, ptr held at 0
    step(1, 0, 0, 4'b0100,  2, 0, 0);   // addr 0x40, owner next cycle; ptr -> 3
    step(1, 0, 0, 4'b0011,  0, 0, 0);   // wrap from 3
    step(1, 0, 0, 4'b0011,  1, 0, 0);
    step(1, 0, 0, 4'b0000, -1, 0, 0);   // ptr stays 2
    step(1, 0, 0, 4'b0000, -1, 0, 0);
    step(1, 0, 0, 4'b1111,  2, 0, 0);
    step(1, 0, 0, 4'b1000,  3, 0, 0);
    step(1, 0, 0, 4'b0001,  0, 0, 0);   // read at t
    step(1, 1, 1, 4'b1111, -1, 0, 0);   // flush at t+1 beats write and reads
    step(1, 1, 0, 4'b1111, -1, 1, 1);   // DRAIN, nothing outstanding: drain_done
    step(1, 0, 0, 4'b1111, -1, 0, 0);   // back in IDLE
    step(1, 0, 0, 4'b1111,  1, 0, 0);   // ACTIVE again, ptr was 1
    step(0, 0, 0, 4'b1111, -1, 0, 0);   // arb_en falls
    step(0, 0, 0, 4'b1111, -1, 1, 1);
    step(1, 0, 0, 4'b0100, -1, 0, 0);
    step(1, 0, 0, 4'b0100,  2, 0, 0);   // read now outstanding

    @(posedge clk); #1;
    rst_n = 1'b0;
    own_q.delete();
    #1 chk_all_zero("midop_reset_outputs");
    arb_en = 1'b0; rd_req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    step(1, 0, 0, 4'b1111, -1, 0, 0);   // IDLE after reset
    step(1, 0, 0, 4'b1111,  0, 0, 0);   // ptr back to 0
    step(0, 0, 0, 4'b0000, -1, 0, 0);
    step(0, 0, 0, 4'b0000, -1, 1, 1);
    step(0, 0, 0, 4'b0000, -1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("grant_q_left", gnt_q.size(), 0);
    chk("owner_q_left", own_q.size(), 0);
    chk("status_q_left", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
